// File: rtl/run_sequencer.sv
// rtl/run_sequencer.sv - launches NPROG core programs back to back, times each run and enforces a watchdog
// Per-program records are pulsed on rec_valid; done/timed_out summarise the whole sequence.
module run_sequencer #(
  parameter int              NPROG        = 3,
  parameter int              PW           = 2,
  parameter int              CW           = 16,
  parameter int              START_CYCLES = 2,
  parameter logic [CW-1:0]   TIMEOUT      = 16'd4000
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          go,
  input  logic          dut_halt,
  output logic          dut_start,
  output logic [PW-1:0] prog_sel,
  output logic          busy,
  output logic          done,
  output logic          timed_out,
  output logic          rec_valid,
  output logic [PW-1:0] rec_prog,
  output logic [CW-1:0] rec_cycles
);

  localparam int            SW         = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [SW-1:0] START_LAST = SW'(START_CYCLES - 1);
  localparam logic [PW-1:0] LAST_PROG  = PW'(NPROG - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_RECORD,
    S_NEXT,
    S_DONE
  } state_t;

  state_t        state_q;
  logic          go_q;
  logic          abort_q;
  logic [CW-1:0] cnt_q;
  logic [SW-1:0] start_cnt_q;
  logic          dut_start_q;
  logic          busy_q;
  logic          done_q;
  logic          timed_out_q;
  logic          rec_valid_q;
  logic [PW-1:0] prog_sel_q;
  logic [PW-1:0] rec_prog_q;
  logic [CW-1:0] rec_cycles_q;

  logic          launch_d;
  logic [CW-1:0] cnt_d;
  logic [SW-1:0] start_cnt_d;
  logic [PW-1:0] prog_sel_d;

  assign launch_d    = go & ~go_q;
  assign cnt_d       = cnt_q + 1'b1;
  assign start_cnt_d = start_cnt_q + 1'b1;
  assign prog_sel_d  = prog_sel_q + 1'b1;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      go_q         <= 1'b0;
      abort_q      <= 1'b0;
      cnt_q        <= '0;
      start_cnt_q  <= '0;
      dut_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timed_out_q  <= 1'b0;
      rec_valid_q  <= 1'b0;
      prog_sel_q   <= '0;
      rec_prog_q   <= '0;
      rec_cycles_q <= '0;
    end else begin
      go_q        <= go;
      rec_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (launch_d) begin
            state_q     <= S_START;
            prog_sel_q  <= '0;
            timed_out_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b1;
            abort_q     <= 1'b0;
            start_cnt_q <= '0;
            dut_start_q <= 1'b1;
          end
        end
        S_START: begin
          if (start_cnt_q == START_LAST) begin
            dut_start_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= S_RUN;
          end else begin
            start_cnt_q <= start_cnt_d;
          end
        end
        S_RUN: begin
          // Halt wins over the watchdog when both land on the same cycle.
          if (dut_halt) begin
            rec_cycles_q <= cnt_q;
            rec_prog_q   <= prog_sel_q;
            rec_valid_q  <= 1'b1;
            state_q      <= S_RECORD;
          end else if (cnt_q == TIMEOUT) begin
            timed_out_q  <= 1'b1;
            abort_q      <= 1'b1;
            rec_cycles_q <= TIMEOUT;
            rec_prog_q   <= prog_sel_q;
            rec_valid_q  <= 1'b1;
            state_q      <= S_RECORD;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_RECORD: begin
          if (abort_q) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (prog_sel_q == LAST_PROG) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            prog_sel_q  <= prog_sel_d;
            start_cnt_q <= '0;
            dut_start_q <= 1'b1;
            state_q     <= S_START;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dut_start  = dut_start_q;
  assign prog_sel   = prog_sel_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign timed_out  = timed_out_q;
  assign rec_valid  = rec_valid_q;
  assign rec_prog   = rec_prog_q;
  assign rec_cycles = rec_cycles_q;

endmodule

// File: tb/tb_run_sequencer.sv
// tb/tb_run_sequencer.sv - directed bench for run_sequencer
// Instance a uses the default watchdog, instance b a 20-cycle watchdog.
module tb_run_sequencer;

  logic        CLK = 1'b0;
  logic        reset, go_a, go_b, halt_a, halt_b;
  logic        start_a, busy_a, done_a, to_a, rv_a;
  logic        start_b, busy_b, done_b, to_b, rv_b;
  logic [1:0]  ps_a, rp_a, ps_b, rp_b;
  logic [15:0] rc_a, rc_b;

  int checks = 0;
  int failures = 0;
  int nrec_a = 0, nrec_b = 0, nstart_a = 0, nstart_b = 0, dbl = 0;
  logic rv_a_p = 1'b0, rv_b_p = 1'b0, st_a_p = 1'b0, st_b_p = 1'b0;
  int k;

  always #5 CLK = ~CLK;

  run_sequencer #(.NPROG(3), .PW(2), .CW(16), .START_CYCLES(2), .TIMEOUT(16'd4000)) dut_a (
    .CLK(CLK), .reset(reset), .go(go_a), .dut_halt(halt_a), .dut_start(start_a),
    .prog_sel(ps_a), .busy(busy_a), .done(done_a), .timed_out(to_a),
    .rec_valid(rv_a), .rec_prog(rp_a), .rec_cycles(rc_a)
  );

  run_sequencer #(.NPROG(3), .PW(2), .CW(16), .START_CYCLES(2), .TIMEOUT(16'd20)) dut_b (
    .CLK(CLK), .reset(reset), .go(go_b), .dut_halt(halt_b), .dut_start(start_b),
    .prog_sel(ps_b), .busy(busy_b), .done(done_b), .timed_out(to_b),
    .rec_valid(rv_b), .rec_prog(rp_b), .rec_cycles(rc_b)
  );

  always @(posedge CLK) begin
    rv_a_p <= rv_a;
    rv_b_p <= rv_b;
    st_a_p <= start_a;
    st_b_p <= start_b;
    if (rv_a) nrec_a <= nrec_a + 1;
    if (rv_b) nrec_b <= nrec_b + 1;
    if ((rv_a && rv_a_p) || (rv_b && rv_b_p)) dbl <= dbl + 1;
    if (start_a && !st_a_p) nstart_a <= nstart_a + 1;
    if (start_b && !st_b_p) nstart_b <= nstart_b + 1;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_halt(input bit b, input logic v);
    if (b) halt_b = v;
    else   halt_a = v;
  endtask

  // Waits for the next launch pulse on dut_start, then halts after n RUN cycles.
  task automatic run_prog(input bit b, input int n, input int exp_prog, input bit toggle_go);
    int w;
    int slen;
    w = 0;
    while (!(b ? start_b : start_a) && w < 60) begin tick(); w++; end
    chk("start_seen", 32'(b ? start_b : start_a), 1);
    slen = 0;
    while ((b ? start_b : start_a) && slen < 60) begin tick(); slen++; end
    chk("start_len", slen, 2);
    for (int i = 0; i < n; i++) begin
      if (toggle_go) go_a = i[0];
      tick();
    end
    set_halt(b, 1'b1);
    tick();
    chk("rec_valid", 32'(b ? rv_b : rv_a), 1);
    chk("rec_prog", 32'(b ? rp_b : rp_a), exp_prog);
    chk("rec_cycles", 32'(b ? rc_b : rc_a), n);
    set_halt(b, 1'b0);
    if (toggle_go) go_a = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_watchdog observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    reset = 1'b1; go_a = 1'b0; go_b = 1'b0; halt_a = 1'b0; halt_b = 1'b0;
    tick(); tick();
    chk("rst_dut_start", start_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_timed_out", to_a, 0);
    chk("rst_rec_valid", rv_a, 0);
    chk("rst_prog_sel", ps_a, 0);
    chk("rst_rec_cycles", rc_a, 0);
    reset = 1'b0;
    tick();

    // Three programs halting after 10, 25 and 7 RUN cycles.
    go_a = 1'b1;
    tick();
    chk("launch_latency", start_a, 1);
    chk("launch_busy", busy_a, 1);
    go_a = 1'b0;
    run_prog(0, 10, 0, 0);
    run_prog(0, 25, 1, 0);
    run_prog(0, 7, 2, 0);
    tick(); tick();
    chk("seq_done", done_a, 1);
    chk("seq_busy", busy_a, 0);
    chk("seq_timed_out", to_a, 0);
    chk("seq_prog_sel", ps_a, 2);
    chk("seq_rec_hold", rc_a, 7);
    chk("seq_nrec", nrec_a, 3);
    chk("seq_nstart", nstart_a, 3);

    // Watchdog: program 1 never halts.
    go_b = 1'b1;
    tick();
    go_b = 1'b0;
    run_prog(1, 5, 0, 0);
    k = 0;
    while (!start_b && k < 60) begin tick(); k++; end
    k = 0;
    while (start_b && k < 60) begin tick(); k++; end
    k = 0;
    while (!rv_b && k < 100) begin tick(); k++; end
    chk("to_cycles_to_record", k, 21);
    chk("to_rec_prog", rp_b, 1);
    chk("to_rec_cycles", rc_b, 20);
    chk("to_flag", to_b, 1);
    tick();
    chk("to_done", done_b, 1);
    chk("to_busy", busy_b, 0);
    repeat (10) tick();
    chk("to_prog_sel_hold", ps_b, 1);
    chk("to_no_prog2_start", start_b, 0);
    chk("to_nstart", nstart_b, 2);
    chk("to_nrec", nrec_b, 2);

    // Relaunch from DONE: halt at RUN cycle 0, then halt exactly at TIMEOUT.
    go_b = 1'b1;
    tick();
    go_b = 1'b0;
    chk("relaunch_done_clr", done_b, 0);
    chk("relaunch_to_clr", to_b, 0);
    chk("relaunch_busy", busy_b, 1);
    chk("relaunch_prog_sel", ps_b, 0);
    run_prog(1, 0, 0, 0);
    run_prog(1, 20, 1, 0);
    chk("halt_at_timeout_flag", to_b, 0);
    run_prog(1, 3, 2, 0);
    tick(); tick();
    chk("b_seq_done", done_b, 1);
    chk("b_seq_timed_out", to_b, 0);

    // go held high for a whole sequence gives one sequence only.
    go_a = 1'b1;
    tick();
    chk("held_launch", start_a, 1);
    run_prog(0, 4, 0, 0);
    run_prog(0, 5, 1, 0);
    run_prog(0, 6, 2, 0);
    tick(); tick();
    chk("held_done", done_a, 1);
    repeat (5) tick();
    chk("held_no_relaunch", start_a, 0);
    chk("held_nstart", nstart_a, 6);
    go_a = 1'b0;
    tick();
    go_a = 1'b1;
    tick();
    chk("restart_start", start_a, 1);
    chk("restart_done_clr", done_a, 0);
    chk("restart_prog_sel", ps_a, 0);
    go_a = 1'b0;
    run_prog(0, 3, 0, 1);
    run_prog(0, 8, 1, 1);
    run_prog(0, 2, 2, 1);
    tick(); tick();
    chk("glitch_done", done_a, 1);
    chk("glitch_nstart", nstart_a, 9);
    chk("glitch_nrec", nrec_a, 9);
    chk("no_double_rec_valid", dbl, 0);

    // Asynchronous reset in the middle of program 1's RUN.
    go_a = 1'b1;
    tick();
    go_a = 1'b0;
    run_prog(0, 3, 0, 0);
    k = 0;
    while (!start_a && k < 60) begin tick(); k++; end
    k = 0;
    while (start_a && k < 60) begin tick(); k++; end
    repeat (4) tick();
    chk("midrun_busy", busy_a, 1);
    chk("midrun_prog_sel", ps_a, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_busy", busy_a, 0);
    chk("async_prog_sel", ps_a, 0);
    chk("async_rec_cycles", rc_a, 0);
    chk("async_dut_start", start_a, 0);
    tick(); tick();
    reset = 1'b0;
    repeat (4) tick();
    chk("post_rst_rec_valid", rv_a, 0);
    chk("post_rst_nrec", nrec_a, 10);
    chk("post_rst_idle_start", start_a, 0);
    chk("post_rst_done", done_a, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
